// File: rtl/cam_read_register_table.sv
// rtl/cam_read_register_table.sv - camera register read table: local status/control/error plus I2C-backed config and crop reads
// Optional WAIT timeout enabled by defining CAM_RD_TIMEOUT_EN.
module cam_read_register_table #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = 8
) (
  input  logic             sysClk,
  input  logic             sysRst_n,
  input  logic [7:0]       rd_addr,
  input  logic             rd_req,
  output logic             rd_busy,
  input  logic [7:0]       status_in,
  input  logic [7:0]       error_in,
  input  logic             cam_id_in,
  input  logic [1:0]       compression_in,
  input  logic             rgb_in,
  input  logic [IDX_W-1:0] index_in,
  output logic [7:0]       cam_i2c_rd_addr,
  output logic             cam_sel,
  output logic             cam_i2c_rd_req,
  input  logic [15:0]      cam_i2c_rd_data,
  input  logic             cam_i2c_rd_valid,
  output logic [127:0]     resp_data,
  output logic             resp_valid,
  output logic             resp_err,
  output logic             error_clr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOCAL = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  if (IDX_W < 1 || IDX_W > 126 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cam_read_register_table: IDX_W must be 1..126 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]  state;
  logic [7:0]  addr_q;
  logic [1:0]  word_cnt;
  logic [63:0] word_buf;
  logic [63:0] word_buf_nxt;
  logic        is_crop;
  logic        last_word;
  logic [7:0]  i2c_addr;
  logic        timed_out;

  assign is_crop   = (addr_q == 8'h05) || (addr_q == 8'h06);
  assign last_word = is_crop ? (word_cnt == 2'd3) : (word_cnt == 2'd1);
  assign i2c_addr  = is_crop ? (8'h01 + {6'd0, word_cnt}) : (8'h09 + {6'd0, word_cnt});

  // Config words fill upward from bit 0; crop words fill downward from bit 63.
  always_comb begin
    word_buf_nxt = word_buf;
    case ({is_crop, word_cnt})
      3'b000:  word_buf_nxt[15:0]  = cam_i2c_rd_data;
      3'b001:  word_buf_nxt[31:16] = cam_i2c_rd_data;
      3'b100:  word_buf_nxt[63:48] = cam_i2c_rd_data;
      3'b101:  word_buf_nxt[47:32] = cam_i2c_rd_data;
      3'b110:  word_buf_nxt[31:16] = cam_i2c_rd_data;
      3'b111:  word_buf_nxt[15:0]  = cam_i2c_rd_data;
      default: word_buf_nxt = word_buf;
    endcase
  end

`ifdef CAM_RD_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt;

  assign timed_out = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      tcnt <= '0;
    end else if (state == WAIT && !cam_i2c_rd_valid && !timed_out) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      word_cnt        <= '0;
      word_buf        <= '0;
      rd_busy         <= 1'b0;
      cam_i2c_rd_addr <= '0;
      cam_sel         <= 1'b0;
      cam_i2c_rd_req  <= 1'b0;
      resp_data       <= '0;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      error_clr       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      error_clr  <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            addr_q   <= rd_addr;
            word_cnt <= '0;
            word_buf <= '0;
            rd_busy  <= 1'b1;
            case (rd_addr)
              8'h00, 8'h01, 8'h04: state <= LOCAL;
              8'h02, 8'h05: begin
                state   <= ISSUE;
                cam_sel <= 1'b0;
              end
              8'h03, 8'h06: begin
                state   <= ISSUE;
                cam_sel <= 1'b1;
              end
              default: begin
                state      <= DONE;
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_data  <= '0;
              end
            endcase
          end
        end
        LOCAL: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          case (addr_q)
            8'h00:   resp_data <= {120'd0, status_in};
            8'h01:   resp_data <= {{(127 - IDX_W){1'b0}}, index_in, cam_id_in};
            default: begin
              resp_data <= {120'd0, error_in};
              error_clr <= 1'b1;
            end
          endcase
        end
        ISSUE: begin
          cam_i2c_rd_addr <= i2c_addr;
          cam_i2c_rd_req  <= 1'b1;
          state           <= WAIT;
        end
        WAIT: begin
          if (cam_i2c_rd_valid) begin
            cam_i2c_rd_req <= 1'b0;
            word_buf       <= word_buf_nxt;
            if (last_word) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= is_crop ? {64'd0, word_buf_nxt}
                                    : {93'd0, compression_in, rgb_in, word_buf_nxt[31:0]};
            end else begin
              word_cnt <= word_cnt + 2'd1;
              state    <= ISSUE;
            end
          end else if (timed_out) begin
            cam_i2c_rd_req <= 1'b0;
            state          <= DONE;
            resp_valid     <= 1'b1;
            resp_err       <= 1'b1;
            resp_data      <= '0;
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
